// File: rtl/bus_target_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_target_memory_pkg
//  Description : Shared bus widths, beat-count width and FSM state encodings
//                for the bus target memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_target_memory_pkg;

    localparam int DATA_W  = 32;   // address/data bus width
    localparam int BE_W    = 4;    // byte-lane count
    localparam int BURST_W = 8;    // burst_size field (beats - 1)
    localparam int BEAT_W  = 9;    // holds 1..256 beats

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ     = 3'd2,
        ST_READ_END = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_target_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_target_memory_if
//  Description : Shared transaction bus. The initiator (DMA) drives the *IN
//                signals, the target drives the *OUT signals (wired-OR, so a
//                target drives 0 whenever it is not asserting).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_target_memory_if;
    import bus_target_memory_pkg::*;

    logic [DATA_W-1:0]  address_dataIN;
    logic [BE_W-1:0]    byte_enableIN;
    logic [BURST_W-1:0] burst_sizeIN;
    logic               read_n_writeIN;
    logic               begin_transactionIN;
    logic               end_transactionIN;
    logic               data_validIN;
    logic               busyIN;

    logic [DATA_W-1:0]  address_dataOUT;
    logic               end_transactionOUT;
    logic               data_validOUT;
    logic               busyOUT;
    logic               errorOUT;

    modport master (
        output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        input  address_dataOUT, end_transactionOUT, data_validOUT, busyOUT,
               errorOUT
    );

    modport slave (
        input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        output address_dataOUT, end_transactionOUT, data_validOUT, busyOUT,
               errorOUT
    );

endinterface
`default_nettype wire

// File: rtl/bus_target_memory_skid.sv
`default_nettype none
// ============================================================================
//  Module      : bus_target_memory_skid
//  Description : Two-entry read-beat buffer. Entry 0 is the head presented
//                on the bus; push and pop may occur in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_target_memory_skid
    import bus_target_memory_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              push_i,
    input  wire logic [DATA_W-1:0] data_i,
    input  wire logic              pop_i,
    input  wire logic              flush_i,
    output logic                   valid_o,
    output logic [DATA_W-1:0]      data_o,
    output logic [1:0]             count_o
);

    logic [DATA_W-1:0] ent0_q;
    logic [DATA_W-1:0] ent1_q;
    logic [1:0]        cnt_q;

    // Shift-register storage: a pop moves entry 1 into the head slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= data_i;
                    else               ent1_q <= data_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= data_i;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = ent0_q;
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/bus_target_memory.sv
`default_nettype none
// ============================================================================
//  Module      : bus_target_memory
//  Description : Bus target serving single/burst reads and writes from a
//                1-cycle-latency word memory inside a fixed address window.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_target_memory
    import bus_target_memory_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_BITS    = 9
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    bus_target_memory_if.slave        bus,
    output logic [ADDR_BITS-1:0]      memAddress,
    output logic                      memWriteEnable,
    output logic [BE_W-1:0]           memByteEnable,
    output logic [DATA_W-1:0]         memDataIn,
    input  wire logic [DATA_W-1:0]    memDataOut
);

    localparam int SUM_W = ((ADDR_BITS > BURST_W) ? ADDR_BITS : BURST_W) + 1;

    state_t               state_q;
    logic [ADDR_BITS-1:0] word_q;
    logic [BE_W-1:0]      be_q;
    logic [BEAT_W-1:0]    fetch_left_q;   // beats still to fetch / write
    logic [BEAT_W-1:0]    cons_left_q;    // read beats still to hand over
    logic                 inflight_q;     // memDataOut carries a beat this cycle

    logic                 hit;
    logic                 overrun;
    logic [ADDR_BITS-1:0] start_word;
    logic [SUM_W-1:0]     last_word;
    logic                 in_read;
    logic                 pres_valid;
    logic [DATA_W-1:0]    pres_data;
    logic                 consume;
    logic                 issue;
    logic                 wr_fire;
    logic [1:0]           occ;
    logic [1:0]           occ_after;
    logic                 sk_valid;
    logic [DATA_W-1:0]    sk_data;
    logic [1:0]           sk_cnt;
    logic                 sk_push;
    logic                 sk_pop;
    logic                 sk_flush;

    // Window decode and burst-overrun check on the begin cycle
    always_comb begin
        start_word = bus.address_dataIN[ADDR_BITS+1:2];
        hit        = bus.begin_transactionIN &&
                     (bus.address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
        last_word  = SUM_W'(start_word) + SUM_W'(bus.burst_sizeIN);
        overrun    = (last_word > SUM_W'(2**ADDR_BITS - 1));
    end

    // Read beat hand-over and prefetch throttling: beats held in the skid
    // buffer plus the one in flight never exceed two
    always_comb begin
        in_read    = (state_q == ST_READ);
        pres_valid = in_read && (sk_valid || inflight_q);
        pres_data  = sk_valid ? sk_data : memDataOut;
        consume    = pres_valid && !bus.busyIN;
        occ        = sk_cnt + {1'b0, inflight_q};
        occ_after  = occ - {1'b0, consume};
        issue      = in_read && !bus.end_transactionIN &&
                     (fetch_left_q != '0) && (occ_after <= 2'd1);
        sk_push    = in_read && inflight_q && !(!sk_valid && consume);
        sk_pop     = sk_valid && consume;
        sk_flush   = in_read && bus.end_transactionIN;
        wr_fire    = (state_q == ST_WRITE) && bus.data_validIN && (fetch_left_q != '0);
    end

    bus_target_memory_skid u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (sk_push),
        .data_i  (memDataOut),
        .pop_i   (sk_pop),
        .flush_i (sk_flush),
        .valid_o (sk_valid),
        .data_o  (sk_data),
        .count_o (sk_cnt)
    );

    // Transaction FSM with beat counters and word pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            be_q         <= '0;
            fetch_left_q <= '0;
            cons_left_q  <= '0;
            inflight_q   <= 1'b0;
        end else begin
            inflight_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        word_q       <= start_word;
                        be_q         <= bus.byte_enableIN;
                        fetch_left_q <= {1'b0, bus.burst_sizeIN} + BEAT_W'(1);
                        cons_left_q  <= {1'b0, bus.burst_sizeIN} + BEAT_W'(1);
                        if (overrun)                 state_q <= ST_ERROR;
                        else if (bus.read_n_writeIN) state_q <= ST_READ;
                        else                         state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_fire) begin
                        word_q       <= word_q + ADDR_BITS'(1);
                        fetch_left_q <= fetch_left_q - BEAT_W'(1);
                    end
                    if (bus.end_transactionIN) state_q <= ST_IDLE;
                end
                ST_READ: begin
                    inflight_q <= issue;
                    if (issue) begin
                        word_q       <= word_q + ADDR_BITS'(1);
                        fetch_left_q <= fetch_left_q - BEAT_W'(1);
                    end
                    if (consume) cons_left_q <= cons_left_q - BEAT_W'(1);
                    if (bus.end_transactionIN) begin
                        state_q    <= ST_IDLE;
                        inflight_q <= 1'b0;
                    end else if (consume && (cons_left_q == BEAT_W'(1))) begin
                        state_q <= ST_READ_END;
                    end
                end
                ST_READ_END: state_q <= ST_IDLE;
                ST_ERROR:    state_q <= ST_IDLE;
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory port: write path is combinational from the bus beat
    assign memWriteEnable = wr_fire;
    assign memAddress     = (wr_fire || issue) ? word_q : '0;
    assign memByteEnable  = wr_fire ? be_q : '0;
    assign memDataIn      = wr_fire ? bus.address_dataIN : '0;

    // Bus outputs are forced to 0 whenever not asserted (wired-OR bus)
    assign bus.data_validOUT      = pres_valid;
    assign bus.address_dataOUT    = pres_valid ? pres_data : '0;
    assign bus.end_transactionOUT = (state_q == ST_READ_END) || (state_q == ST_ERROR);
    assign bus.errorOUT           = (state_q == ST_ERROR);
    assign bus.busyOUT            = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bus_target_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_target_memory
//  Description : Scoreboard bench for bus_target_memory with a 512-word
//                1-cycle-latency memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_target_memory;

    typedef struct { logic [31:0] data; int cyc; } rd_exp_t;
    typedef struct { logic [8:0] addr; logic [31:0] data; logic [3:0] be; } wr_exp_t;
    typedef struct { bit err; int cyc; } end_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [8:0]  memAddress;
    logic        memWriteEnable;
    logic [3:0]  memByteEnable;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;
    logic [31:0] mem [512];
    logic [31:0] ref_mem [512];

    rd_exp_t  exp_rd[$];
    wr_exp_t  exp_wr[$];
    end_exp_t exp_end[$];

    bus_target_memory_if bif ();

    bus_target_memory dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bif),
        .memAddress     (memAddress),
        .memWriteEnable (memWriteEnable),
        .memByteEnable  (memByteEnable),
        .memDataIn      (memDataIn),
        .memDataOut     (memDataOut)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: byte-lane writes, registered read data
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i);
        end else if (memWriteEnable) begin
            for (int b = 0; b < 4; b++)
                if (memByteEnable[b]) mem[memAddress][8*b +: 8] <= memDataIn[8*b +: 8];
        end
        memDataOut <= mem[memAddress];
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic bit all_zero();
        return (bif.address_dataOUT == 32'd0) && !bif.end_transactionOUT &&
               !bif.data_validOUT && !bif.busyOUT && !bif.errorOUT &&
               (memAddress == 9'd0) && !memWriteEnable &&
               (memByteEnable == 4'd0) && (memDataIn == 32'd0);
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response
    bit prev_held = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bif.data_validOUT) begin
                    if (exp_rd.size() == 0) begin
                        check(1'b0, "rd_unexpected", 64'(bif.address_dataOUT), 64'd0);
                    end else begin
                        check(bif.address_dataOUT == exp_rd[0].data, "rd_data",
                              64'(bif.address_dataOUT), 64'(exp_rd[0].data));
                        if (exp_rd[0].cyc >= 0 && !prev_held)
                            check(cyc == exp_rd[0].cyc, "rd_cycle", 64'(cyc), 64'(exp_rd[0].cyc));
                        if (!bif.busyIN) void'(exp_rd.pop_front());
                    end
                    prev_held = bif.busyIN;
                end else begin
                    prev_held = 1'b0;
                    if (bif.address_dataOUT != 32'd0)
                        check(1'b0, "rd_idle_zero", 64'(bif.address_dataOUT), 64'd0);
                end
                if (memWriteEnable) begin
                    if (exp_wr.size() == 0) begin
                        check(1'b0, "wr_unexpected", 64'(memAddress), 64'd0);
                    end else begin
                        check(memAddress == exp_wr[0].addr && memDataIn == exp_wr[0].data &&
                              memByteEnable == exp_wr[0].be, "wr_beat",
                              {19'd0, memAddress, memByteEnable, memDataIn},
                              {19'd0, exp_wr[0].addr, exp_wr[0].be, exp_wr[0].data});
                        void'(exp_wr.pop_front());
                    end
                end
                if (bif.end_transactionOUT) begin
                    if (exp_end.size() == 0) begin
                        check(1'b0, "end_unexpected", 64'(bif.errorOUT), 64'd0);
                    end else begin
                        check(bif.errorOUT == exp_end[0].err, "end_error_flag",
                              64'(bif.errorOUT), 64'(exp_end[0].err));
                        if (exp_end[0].cyc >= 0)
                            check(cyc == exp_end[0].cyc, "end_cycle", 64'(cyc), 64'(exp_end[0].cyc));
                        if (bif.errorOUT)
                            check(memAddress == 9'd0 && !memWriteEnable, "err_no_mem_access",
                                  64'(memAddress), 64'd0);
                        void'(exp_end.pop_front());
                    end
                end else if (bif.errorOUT) begin
                    check(1'b0, "error_without_end", 64'd1, 64'd0);
                end
            end
        end
    end

    task automatic idle_inputs();
        bif.address_dataIN      = '0;
        bif.byte_enableIN       = '0;
        bif.burst_sizeIN        = '0;
        bif.read_n_writeIN      = 1'b0;
        bif.begin_transactionIN = 1'b0;
        bif.end_transactionIN   = 1'b0;
        bif.data_validIN        = 1'b0;
        bif.busyIN              = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_rd.size() != 0 || exp_wr.size() != 0 || exp_end.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(n < 300, name, 64'(exp_rd.size() + exp_wr.size() + exp_end.size()), 64'd0);
        bif.busyIN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Read: busyIN high for cycles T+blo..T+bhi (relative to begin cycle T)
    task automatic rd(input logic [31:0] addr, input logic [7:0] bsz, input bit timed,
                      input int blo, input int bhi, input bit exp_err);
        int t;
        int beats;
        logic [8:0] w;
        @(posedge clk); #1;
        bif.address_dataIN      = addr;
        bif.burst_sizeIN        = bsz;
        bif.read_n_writeIN      = 1'b1;
        bif.byte_enableIN       = 4'hF;
        bif.begin_transactionIN = 1'b1;
        t     = cyc;
        beats = int'(bsz) + 1;
        w     = addr[10:2];
        if (exp_err) begin
            exp_end.push_back('{1'b1, timed ? t + 1 : -1});
        end else begin
            for (int i = 0; i < beats; i++)
                exp_rd.push_back('{ref_mem[w + 9'(i)], timed ? t + 2 + i : -1});
            exp_end.push_back('{1'b0, timed ? t + 2 + beats : -1});
        end
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 0; k < 40 && (exp_rd.size() != 0 || exp_end.size() != 0); k++) begin
            bif.busyIN = ((cyc - t) >= blo) && ((cyc - t) <= bhi);
            @(posedge clk); #1;
        end
        wait_done("rd_complete");
    endtask

    // Write: nbeats data beats, end_transactionIN on the last one
    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] bsz,
                      input int nbeats, input logic [31:0] dat [3]);
        logic [8:0] w;
        @(posedge clk); #1;
        bif.address_dataIN      = addr;
        bif.byte_enableIN       = be;
        bif.burst_sizeIN        = bsz;
        bif.read_n_writeIN      = 1'b0;
        bif.begin_transactionIN = 1'b1;
        for (int i = 0; i < nbeats && i <= int'(bsz); i++) begin
            w = addr[10:2] + 9'(i);
            exp_wr.push_back('{w, dat[i], be});
            ref_mem[w] = merge(ref_mem[w], dat[i], be);
        end
        @(posedge clk); #1;
        idle_inputs();
        for (int i = 0; i < nbeats; i++) begin
            bif.data_validIN      = 1'b1;
            bif.address_dataIN    = dat[i];
            bif.end_transactionIN = (i == nbeats - 1);
            @(posedge clk); #1;
        end
        idle_inputs();
        wait_done("wr_complete");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d [3];
        bit quiet;
        int n;
        idle_inputs();
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'(i);
        load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(all_zero(), "reset_outputs", 64'(bif.address_dataOUT), 64'd0);
        load  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Burst of 4 from word 0, exact cycle timing
        rd(32'h5000_0000, 8'd3, 1'b1, -1, -1, 1'b0);
        // Same burst with busy on the 2nd and 3rd beat cycles
        rd(32'h5000_0000, 8'd3, 1'b0, 3, 4, 1'b0);
        // Single write to word 4, end on the same cycle as the beat
        d[0] = 32'hA5A5_A5A5; d[1] = '0; d[2] = '0;
        wr(32'h5000_0010, 4'hF, 8'd0, 1, d);
        rd(32'h5000_0010, 8'd0, 1'b0, -1, -1, 1'b0);
        // Two-beat burst with partial lanes and an extra beat that is dropped
        d[0] = 32'h1122_3344; d[1] = 32'h5566_7788; d[2] = 32'h99AA_BBCC;
        wr(32'h5000_0050, 4'b0101, 8'd1, 3, d);
        rd(32'h5000_0050, 8'd2, 1'b0, -1, -1, 1'b0);
        // Overrun at the top of the window (word 510 + 3)
        rd(32'h5000_07F8, 8'd3, 1'b1, -1, -1, 1'b1);
        // Exact fit to the last word is legal
        rd(32'h5000_07F8, 8'd1, 1'b0, 2, 6, 1'b0);
        // Long burst with an irregular busy window
        rd(32'h5000_0100, 8'd9, 1'b0, 4, 8, 1'b0);

        // Miss outside the window: no response at all
        @(posedge clk); #1;
        bif.address_dataIN      = 32'h6000_0000;
        bif.read_n_writeIN      = 1'b1;
        bif.begin_transactionIN = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        quiet = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (!all_zero()) quiet = 1'b0;
        end
        check(quiet, "miss_quiet", 64'(!quiet), 64'd0);

        // Abort a read after two beats
        @(posedge clk); #1;
        bif.address_dataIN      = 32'h5000_0000;
        bif.burst_sizeIN        = 8'd7;
        bif.read_n_writeIN      = 1'b1;
        bif.begin_transactionIN = 1'b1;
        exp_rd.push_back('{ref_mem[0], cyc + 2});
        exp_rd.push_back('{ref_mem[1], cyc + 3});
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        bif.end_transactionIN = 1'b1;
        @(posedge clk); #1;
        bif.end_transactionIN = 1'b0;
        @(negedge clk);
        check(all_zero(), "abort_outputs_zero", 64'(bif.address_dataOUT), 64'd0);
        wait_done("abort_complete");

        // Reset in the middle of a read burst
        @(posedge clk); #1;
        bif.address_dataIN      = 32'h5000_0020;
        bif.burst_sizeIN        = 8'd7;
        bif.read_n_writeIN      = 1'b1;
        bif.begin_transactionIN = 1'b1;
        for (int i = 0; i < 8; i++) exp_rd.push_back('{ref_mem[8 + i], -1});
        exp_end.push_back('{1'b0, -1});
        @(posedge clk); #1;
        idle_inputs();
        n = 0;
        while (exp_rd.size() > 5 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(n < 50, "reset_test_progress", 64'(exp_rd.size()), 64'd5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check(all_zero(), "async_reset_zero", 64'(bif.data_validOUT), 64'd0);
        exp_rd.delete();
        exp_end.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(32'h5000_0014, 8'd0, 1'b1, -1, -1, 1'b0);

        check(exp_rd.size() == 0 && exp_wr.size() == 0 && exp_end.size() == 0,
              "scoreboard_empty", 64'(exp_rd.size() + exp_wr.size() + exp_end.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
